// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master among N requesters: grant, start strobe, track LOAD, return rx word.
// Round-robin by default; define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module spi_xfer_arbiter #(
   parameter int unsigned N   = 4,
   parameter int unsigned M   = 8,
   parameter int unsigned GAP = 2
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [N-1:0]   i_req,
   input  logic [N*M-1:0] i_tx_dat,
   output logic [N-1:0]   o_gnt,
   output logic [N-1:0]   o_done,
   output logic [M-1:0]   o_rx_dat,
   output logic           o_busy,
   output logic           o_spi_st,
   output logic [M-1:0]   o_spi_mtx_dat,
   input  logic           i_spi_load,
   input  logic [M-1:0]   i_spi_mrx_dat
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned GW = $clog2(GAP + 1);

   typedef enum logic [2:0] {StIdle, StStart, StWaitLo, StWaitHi, StCapt} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [GW-1:0] r_gap_cnt;
   logic          r_load_prev;
   logic [N-1:0]  r_gnt;
   logic [N-1:0]  r_done;
   logic [M-1:0]  r_rx_dat;
   logic [M-1:0]  r_mtx_dat;
   logic          r_st;

   logic          w_gap_ok;
   logic          w_load_rise;
   logic          w_found;
   logic          w_grant;
   logic          w_st_nxt;
   logic          w_busy;
   logic [PW-1:0] w_win;
   logic [N-1:0]  w_win_oh;
   logic [M-1:0]  w_win_dat;

   assign w_gap_ok    = (r_gap_cnt == GW'(GAP));
   assign w_load_rise = ~r_load_prev & i_spi_load;
   assign w_grant     = (r_state == StIdle) & w_found & w_gap_ok;
   assign w_win_oh    = N'(1) << w_win;
   assign w_win_dat   = i_tx_dat[32'(w_win) * M +: M];

`ifdef SPI_ARB_FIXED_PRIO_EN
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_found = 1'b1;
            w_win   = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;

   // Search starts one past the last winner and wraps at N.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = r_ptr;
      for (int k = 0; k < N; k++) begin
         w_idx = (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= PW'(N - 1);
      end else if (w_grant) begin
         r_ptr <= w_win;
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:   if (w_grant) w_state_nxt = StStart;
         StStart:  w_state_nxt = StWaitLo;
         StWaitLo: if (!i_spi_load) w_state_nxt = StWaitHi;
         StWaitHi: if (w_load_rise) w_state_nxt = StCapt;
         StCapt:   w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_st_nxt = (r_state == StStart);
      w_busy   = (r_state != StIdle);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_gap_cnt   <= '0;
         r_load_prev <= 1'b1;
         r_gnt       <= '0;
         r_done      <= '0;
         r_rx_dat    <= '0;
         r_mtx_dat   <= '0;
         r_st        <= 1'b0;
      end else begin
         r_load_prev <= i_spi_load;
         r_st        <= w_st_nxt;
         r_done      <= '0;
         // A low LOAD in idle means someone else is using the master; restart the gap.
         if (r_state == StIdle) begin
            if (!i_spi_load) begin
               r_gap_cnt <= '0;
            end else if (!w_gap_ok) begin
               r_gap_cnt <= r_gap_cnt + 1'b1;
            end
         end
         if (w_grant) begin
            r_gnt     <= w_win_oh;
            r_mtx_dat <= w_win_dat;
         end
         if (r_state == StCapt) begin
            r_rx_dat  <= i_spi_mrx_dat;
            r_done    <= r_gnt;
            r_gnt     <= '0;
            r_gap_cnt <= '0;
         end
      end
   end

   assign o_gnt         = r_gnt;
   assign o_done        = r_done;
   assign o_rx_dat      = r_rx_dat;
   assign o_busy        = w_busy;
   assign o_spi_st      = r_st;
   assign o_spi_mtx_dat = r_mtx_dat;

endmodule
